// File: rtl/field_extract_pipe.sv
// Bit-field extract/extend: (in >> shift), keep len low bits, zero- or sign-extend back to WIDTH.
// Latency 2 cycles from input accept to out_valid; throughput 1 transaction per cycle.
// Backpressure: stages advance only when downstream frees; in_ready is combinational from out_ready.
module field_extract_pipe #(
    parameter int WIDTH = 32,
    parameter int LEN_W = $clog2(WIDTH + 1),
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [SH_W-1:0]  shift,
    input  logic [LEN_W-1:0] len,
    input  logic             sign_ext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             err
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

    // Stage 1 state: shifted operand, clamped length, extend mode, clamp flag.
    logic             s1_valid;
    logic [WIDTH-1:0] s1_shifted;
    logic [LEN_W-1:0] s1_len;
    logic             s1_sext;
    logic             s1_err;

    // Stage 2 state; its payload is the module output directly.
    logic             s2_valid;

    // Stage-1 combinational front end and stage-2 result.
    logic [WIDTH-1:0] shifted_d;
    logic [LEN_W-1:0] len_d;
    logic             err_d;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] field;
    logic             sign_bit;
    logic [WIDTH-1:0] result;

    logic s2_adv;
    logic s1_adv;

    // Pipeline advance conditions; S2 frees first so a full pipe still streams at full rate.
    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = s2_adv || !s1_valid;
        in_ready = s1_adv;
    end

    assign out_valid = s2_valid;

    // Front end: logical right shift (amounts >= WIDTH naturally give zero) and len clamp.
    always_comb begin
        shifted_d = in >> shift;
        len_d     = len;
        err_d     = 1'b0;
        if (len > LEN_MAX) begin
            len_d = LEN_MAX;
            err_d = 1'b1;
        end
    end

    // Mask/extend: the sign bit is the field bit under the top bit of the mask, so len==0 never extends.
    always_comb begin
        if (s1_len == LEN_MAX) begin
            mask = '1;
        end else begin
            mask = (WIDTH'(1) << s1_len) - WIDTH'(1);
        end
        field    = s1_shifted & mask;
        sign_bit = |(field & (mask ^ (mask >> 1)));
        result   = field;
        if (s1_sext && sign_bit) begin
            result = field | ~mask;
        end
    end

    // Stage 1 register: captures a new transaction whenever it can hand its current one on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_shifted <= '0;
            s1_len     <= '0;
            s1_sext    <= 1'b0;
            s1_err     <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_shifted <= shifted_d;
                s1_len     <= len_d;
                s1_sext    <= sign_ext;
                s1_err     <= err_d;
            end
        end
    end

    // Stage 2 register: holds out/err steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out      <= '0;
            err      <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out <= result;
                err <= s1_err;
            end
        end
    end

endmodule
